// File: rtl/nh_window_sched.sv
// Raster pixel sequencer for the neighbourhood shift register / line buffers.
// Tracks row/col, gates each shift and flags the shifts that complete a full NH_DIM x NH_DIM window.
module nh_window_sched #(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int NH_DIM     = 3,
  parameter int PIX_W      = 24,
  parameter int COL_W      = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
  parameter int ROW_W      = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_in,
  output logic             pix_rdy,
  output logic             sr_clear,
  output logic             shift_en,
  output logic [PIX_W-1:0] shift_data,
  output logic             win_valid,
  output logic [ROW_W-1:0] win_row,
  output logic [COL_W-1:0] win_col,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_NH   = COL_W'(NH_DIM - 1);
  localparam logic [ROW_W-1:0] ROW_NH   = ROW_W'(NH_DIM - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_STREAM, S_FLUSH} state_t;

  state_t           state, state_nxt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             accept, last_col, last_row, completes;
  logic             s1_win, s1_last;
  logic [ROW_W-1:0] s1_row;
  logic [COL_W-1:0] s1_col;

  assign accept    = pix_valid & pix_rdy;
  assign last_col  = (col == COL_LAST);
  assign last_row  = (row == ROW_LAST);
  assign completes = (row >= ROW_NH) && (col >= COL_NH);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FLUSH leaves once the shift stage is empty; the window stage drains on the same edge.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_CLEAR;
      S_CLEAR:  state_nxt = S_STREAM;
      S_STREAM: if (accept && last_col && last_row) state_nxt = S_FLUSH;
      S_FLUSH:  if (!shift_en) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pix_rdy  = 1'b0;
    sr_clear = 1'b0;
    busy     = 1'b1;
    case (state)
      S_IDLE:   busy     = 1'b0;
      S_CLEAR:  sr_clear = 1'b1;
      S_STREAM: pix_rdy  = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (state == S_CLEAR) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (last_col) begin
        col <= '0;
        if (!last_row) row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Stage 1: shift strobe plus the window tag travelling with the pixel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_en   <= 1'b0;
      shift_data <= '0;
      s1_win     <= 1'b0;
      s1_last    <= 1'b0;
      s1_row     <= '0;
      s1_col     <= '0;
    end else begin
      shift_en <= accept;
      s1_win   <= accept & completes;
      s1_last  <= accept & last_col & last_row;
      if (accept) begin
        shift_data <= pix_in;
        s1_row     <= row - ROW_NH;
        s1_col     <= col - COL_NH;
      end
    end
  end

  // Stage 2: window strobe once the pixel is resident in the datapath.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
    end else begin
      win_valid  <= s1_win;
      frame_done <= s1_win & s1_last;
      if (s1_win) begin
        win_row <= s1_row;
        win_col <= s1_col;
      end
    end
  end

endmodule

// File: tb/tb_nh_window_sched.sv
// Bench for nh_window_sched: event-scheduling model of the frame protocol checked every cycle,
// plus literal per-frame expectations (window list, latencies) and a 2x2 corner instance.
module tb_nh_window_sched;
  localparam int W = 5, H = 4, N = 3, PW = 24, RW = 2, CW = 3;
  localparam int INF = 1 << 30;
  localparam int DEPTH = 1024;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          start = 1'b0, pix_valid = 1'b0;
  logic [PW-1:0] pix_in = '0;
  logic          pix_rdy, sr_clear, shift_en, win_valid, busy, frame_done;
  logic [PW-1:0] shift_data;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;

  nh_window_sched #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .NH_DIM(N), .PIX_W(PW)) dut (
    .clock(clock), .reset(reset), .start(start), .pix_valid(pix_valid), .pix_in(pix_in),
    .pix_rdy(pix_rdy), .sr_clear(sr_clear), .shift_en(shift_en), .shift_data(shift_data),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col), .busy(busy),
    .frame_done(frame_done));

  logic       start2 = 1'b0, pv2 = 1'b0;
  logic [7:0] pd2 = 8'h5a;
  logic       rdy2, clr2, sh2, wv2, busy2, done2;
  logic [7:0] sd2;
  logic [0:0] wr2, wc2;

  nh_window_sched #(.IMG_WIDTH(2), .IMG_HEIGHT(2), .NH_DIM(2), .PIX_W(8)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .pix_valid(pv2), .pix_in(pd2),
    .pix_rdy(rdy2), .sr_clear(clr2), .shift_en(sh2), .shift_data(sd2),
    .win_valid(wv2), .win_row(wr2), .win_col(wc2), .busy(busy2), .frame_done(done2));

  // Expected outputs, indexed by cycle (cycle n = interval after the n-th rising edge).
  bit          exp_rdy [DEPTH], exp_clr [DEPTH], exp_shift [DEPTH], exp_win [DEPTH];
  bit          exp_done[DEPTH], exp_busy[DEPTH];
  logic [PW-1:0] exp_data[DEPTH];
  int          exp_row [DEPTH], exp_col [DEPTH];
  int          cyc = 0, idle_from = 0, stream_from = INF, npix = 0;

  // Frame rules: start seen while idle -> clear next cycle, ready the cycle after;
  // pixel k = (k/W, k%W) accepted in cycle t shifts at t+1, windows at t+2.
  always @(posedge clock) begin
    int k, r, c;
    cyc++;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        exp_rdy[cyc+i] = 0; exp_clr[cyc+i] = 0; exp_shift[cyc+i] = 0;
        exp_win[cyc+i] = 0; exp_done[cyc+i] = 0; exp_busy[cyc+i] = 0;
      end
      idle_from   = cyc;
      stream_from = INF;
    end else begin
      if (cyc - 1 >= idle_from && start) begin
        idle_from    = INF;
        exp_clr[cyc] = 1; exp_busy[cyc] = 1;
        stream_from  = cyc + 1;
        npix         = 0;
      end else if (exp_rdy[cyc-1] && pix_valid) begin
        k = npix; npix++;
        r = k / W; c = k % W;
        exp_shift[cyc] = 1; exp_data[cyc] = pix_in;
        if (r >= N - 1 && c >= N - 1) begin
          exp_win[cyc+1] = 1; exp_row[cyc+1] = r - (N - 1); exp_col[cyc+1] = c - (N - 1);
        end
        if (npix == W * H) begin
          exp_done[cyc+1] = 1; exp_busy[cyc] = 1; exp_busy[cyc+1] = 1;
          stream_from = INF;
          idle_from   = cyc + 2;
        end
      end
      if (cyc >= stream_from) begin
        exp_rdy[cyc] = 1; exp_busy[cyc] = 1;
      end
    end
  end

  int errors = 0, checks = 0;
  int hold_r = 0, hold_c = 0;
  int win_n = 0, shift_n = 0, first_win = -1, done_cyc = -1, busy_drop = -1;
  int wr[8], wc[8];
  bit prev_busy = 0;
  int win2_n = 0, shift2_n = 0, win2_cyc = -1, done2_cyc = -1, busy2_drop = -1;
  int win2_r = -1, win2_c = -1;
  bit prev_busy2 = 0;
  int exp_wr[6] = '{0, 0, 0, 1, 1, 1};
  int exp_wc[6] = '{0, 1, 2, 0, 1, 2};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare();
    if (reset) begin
      hold_r = 0; hold_c = 0;
      chk("reset_outputs", 64'({pix_rdy, sr_clear, shift_en, win_valid, busy, frame_done,
                                win_row, win_col, shift_data}), 64'd0);
    end else begin
      chk("pix_rdy",    64'(pix_rdy),    64'(exp_rdy[cyc]));
      chk("sr_clear",   64'(sr_clear),   64'(exp_clr[cyc]));
      chk("shift_en",   64'(shift_en),   64'(exp_shift[cyc]));
      chk("busy",       64'(busy),       64'(exp_busy[cyc]));
      chk("win_valid",  64'(win_valid),  64'(exp_win[cyc]));
      chk("frame_done", 64'(frame_done), 64'(exp_done[cyc]));
      if (exp_shift[cyc]) chk("shift_data", 64'(shift_data), 64'(exp_data[cyc]));
      if (exp_win[cyc]) begin hold_r = exp_row[cyc]; hold_c = exp_col[cyc]; end
      chk("win_row", 64'(win_row), 64'(hold_r));
      chk("win_col", 64'(win_col), 64'(hold_c));
    end
    if (exp_clr[cyc] && !reset) begin
      win_n = 0; shift_n = 0; first_win = -1; done_cyc = -1; busy_drop = -1;
    end
    if (shift_en) shift_n++;
    if (win_valid) begin
      if (win_n < 8) begin wr[win_n] = int'(win_row); wc[win_n] = int'(win_col); end
      if (win_n == 0) first_win = cyc;
      win_n++;
    end
    if (frame_done) done_cyc = cyc;
    if (prev_busy && !busy) busy_drop = cyc;
    prev_busy = busy;
    if (sh2) shift2_n++;
    if (wv2) begin win2_n++; win2_cyc = cyc; win2_r = int'(wr2); win2_c = int'(wc2); end
    if (done2) done2_cyc = cyc;
    if (prev_busy2 && !busy2) busy2_drop = cyc;
    prev_busy2 = busy2;
  endtask

  task automatic step();
    @(negedge clock);
    compare();
    @(posedge clock);
    #1;
  endtask

  task automatic run_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic drive_frame(input int ncyc, input bit toggle, input int start_len, output int s);
    s = cyc;
    start = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      step();
      if (i + 1 >= start_len) start = 1'b0;
      pix_valid = toggle ? (i % 2 == 0) : 1'b1;
      pix_in    = PW'($urandom);
    end
    step();
    pix_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic check_frame(input string name, input int s, input int first_off, input int done_off);
    chk({name, "_win_count"},   64'(win_n),   64'd6);
    for (int i = 0; i < 6; i++) begin
      chk({name, "_win_row"}, 64'(wr[i]), 64'(exp_wr[i]));
      chk({name, "_win_col"}, 64'(wc[i]), 64'(exp_wc[i]));
    end
    chk({name, "_shift_count"}, 64'(shift_n),       64'd20);
    chk({name, "_first_win"},   64'(first_win - s), 64'(first_off));
    chk({name, "_frame_done"},  64'(done_cyc - s),  64'(done_off));
    chk({name, "_busy_drop"},   64'(busy_drop - s), 64'(done_off + 1));
  endtask

  initial begin
    int s;
    reset = 1'b1;
    repeat (3) step();
    chk("reset_busy",     64'(busy),       64'd0);
    chk("reset_rdy",      64'(pix_rdy),    64'd0);
    chk("reset_shift",    64'(shift_en),   64'd0);
    chk("reset_win",      64'(win_valid),  64'd0);
    chk("reset_done",     64'(frame_done), 64'd0);
    reset = 1'b0;
    step();
    step();

    // Back-to-back frame: accepts s+2..s+21, 13th at s+14 -> first window s+16, done s+23.
    drive_frame(22, 1'b0, 1, s);
    run_until(s + 30);
    check_frame("b2b", s, 16, 23);

    // Alternating valid: accepts s+3, s+5, ..., s+41.
    drive_frame(42, 1'b1, 1, s);
    run_until(s + 50);
    check_frame("toggle", s, 29, 43);

    // start held high through most of the stream must not restart the frame.
    drive_frame(22, 1'b0, 15, s);
    run_until(s + 30);
    check_frame("start_held", s, 16, 23);

    // Abort after 9 accepted pixels; the 9th pixel's shift is on the outputs when reset hits.
    drive_frame(10, 1'b0, 1, s);
    reset = 1'b1;
    #1;
    chk("abort_async_shift", 64'(shift_en), 64'd0);
    chk("abort_async_busy",  64'(busy),     64'd0);
    chk("abort_async_rdy",   64'(pix_rdy),  64'd0);
    step();
    step();
    reset = 1'b0;
    run_until(cyc + 6);
    chk("abort_shift_count", 64'(shift_n), 64'd8);
    chk("abort_win_count",   64'(win_n),   64'd0);

    drive_frame(22, 1'b0, 1, s);
    run_until(s + 30);
    check_frame("after_abort", s, 16, 23);

    // 2x2 image with 2x2 window: single window on the last pixel (accepted at s+5).
    s = cyc;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    pv2 = 1'b1;
    repeat (5) step();
    pv2 = 1'b0;
    run_until(s + 12);
    chk("dim2_win_count",   64'(win2_n),         64'd1);
    chk("dim2_shift_count", 64'(shift2_n),       64'd4);
    chk("dim2_win_cycle",   64'(win2_cyc - s),   64'd7);
    chk("dim2_done_cycle",  64'(done2_cyc - s),  64'd7);
    chk("dim2_win_row",     64'(win2_r),         64'd0);
    chk("dim2_win_col",     64'(win2_c),         64'd0);
    chk("dim2_busy_drop",   64'(busy2_drop - s), 64'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
